// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock supervisor and its surroundings.
// master: the supervisor itself; slave: PLL wrapper / downstream reset consumer.
interface pll_lock_ctrl_if;
    logic       pll_lock_i;
    logic       force_relock_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       locked_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;

    modport master (
        input  pll_lock_i,
        input  force_relock_i,
        output pll_rst_o,
        output sys_rst_o,
        output locked_o,
        output fault_o,
        output retry_cnt_o
    );

    modport slave (
        output pll_lock_i,
        output force_relock_i,
        input  pll_rst_o,
        input  sys_rst_o,
        input  locked_o,
        input  fault_o,
        input  retry_cnt_o
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock supervisor: pulses PLL reset, qualifies LOCK, retries on timeout,
// and releases the downstream reset only while the PLL is qualified locked.
module pll_lock_ctrl #(
    parameter int unsigned RST_HOLD_CYC     = 16,
    parameter int unsigned LOCK_FILT_CYC    = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned RETRY_MAX        = 7
) (
    input  logic                  clkin1,
    input  logic                  rst,
    pll_lock_ctrl_if.master       bus
);

    localparam int unsigned MAX_AB  = (RST_HOLD_CYC > LOCK_FILT_CYC) ? RST_HOLD_CYC : LOCK_FILT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [3:0]       RETRY_LIM = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d, retry_inc;
    logic             lock_meta, lock_s;
    logic             pll_rst_q, sys_rst_q, locked_q, fault_q;
    logic             pll_rst_d, sys_rst_d, locked_d, fault_d;

    // LOCK comes straight from the PLL analog block, asynchronous to clkin1.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

        if (bus.force_relock_i) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_FILTER;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_LIM) ? S_FAULT : S_RESET_PLL;
                    end
                end
                S_FILTER: begin
                    // A glitch restarts the timeout window but is not a failed attempt.
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == FILT_LAST) begin
                        state_d = S_LOCKED;
                        retry_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (!lock_s) state_d = S_RESET_PLL;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_RESET_PLL;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.force_relock_i || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q inside {S_RESET_PLL, S_WAIT_LOCK, S_FILTER}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they land on the same edge as the state.
    always_comb begin
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_LOCKED);
        locked_d  = (state_d == S_LOCKED);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.pll_rst_o   = pll_rst_q;
    assign bus.sys_rst_o   = sys_rst_q;
    assign bus.locked_o    = locked_q;
    assign bus.fault_o     = fault_q;
    assign bus.retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: constant vector table, directed corner
// sequences, and randomized LOCK/force/rst traffic against a counter-based model.
module tb_pll_lock_ctrl;

    localparam int unsigned RST_HOLD  = 4;
    localparam int unsigned FILT      = 8;
    localparam int unsigned TIMEOUT   = 32;
    localparam int unsigned RMAX      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_ctrl_if bus ();

    pll_lock_ctrl #(
        .RST_HOLD_CYC     (RST_HOLD),
        .LOCK_FILT_CYC    (FILT),
        .LOCK_TIMEOUT_CYC (TIMEOUT),
        .RETRY_MAX        (RMAX)
    ) dut (
        .clkin1 (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    // Reference model: phases are implied by counters rather than a state variable.
    bit m_h0, m_h1;
    bit m_fault, m_locked;
    int m_rst_left, m_age, m_run, m_retry;

    task automatic model_reset();
        m_h0 = 0; m_h1 = 0;
        m_fault = 0; m_locked = 0;
        m_rst_left = RST_HOLD; m_age = 0; m_run = 0; m_retry = 0;
    endtask

    task automatic model_step(input bit r, input bit lk, input bit fr);
        bit s;
        if (r) begin
            model_reset();
            return;
        end
        s = m_h1;
        m_h1 = m_h0;
        m_h0 = lk;
        if (fr) begin
            m_rst_left = RST_HOLD; m_fault = 0; m_locked = 0;
            m_retry = 0; m_run = 0; m_age = 0;
        end else if (m_fault) begin
            // sticky
        end else if (m_locked) begin
            if (!s) begin
                m_locked = 0;
                m_rst_left = RST_HOLD;
            end
        end else if (m_rst_left > 0) begin
            m_rst_left--;
            m_age = 0;
            m_run = 0;
        end else if (m_run > 0) begin
            if (!s) begin
                m_run = 0;
                m_age = 0;
            end else begin
                m_run++;
                if (m_run == FILT + 1) begin
                    m_locked = 1; m_retry = 0; m_run = 0;
                end
            end
        end else if (s) begin
            m_run = 1;
        end else begin
            m_age++;
            if (m_age == TIMEOUT) begin
                m_age = 0;
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                if (m_retry == RMAX) m_fault = 1;
                else m_rst_left = RST_HOLD;
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] r4;
        r4 = 4'(m_retry);
        return {(m_fault || m_rst_left > 0), !m_locked, m_locked, m_fault, r4};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.pll_rst_o, bus.sys_rst_o, bus.locked_o, bus.fault_o, bus.retry_cnt_o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit lk, input bit fr);
        rst = r;
        bus.pll_lock_i = lk;
        bus.force_relock_i = fr;
        @(posedge clk);
        model_step(r, lk, fr);
        #1;
        check("model", {24'd0, dut_out()}, {24'd0, model_out()});
    endtask

    task automatic reset_dut();
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    // Counts pll_rst_o-high samples (current one included) while lock is held at lk.
    task automatic count_pll_pulse(input bit lk, output int hi);
        hi = bus.pll_rst_o ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(0, lk, 0);
            if (!bus.pll_rst_o) break;
            hi++;
        end
    endtask

    task automatic wait_locked(output bit seen);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0);
            if (bus.locked_o) begin
                seen = 1;
                break;
            end
        end
    endtask

    typedef struct {
        bit          r;
        bit          lk;
        bit          fr;
        int unsigned n;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hi;
        bit  seen;
        bit  lk;
        bit  fr;
        bit  r;

        bus.pll_lock_i = 0;
        bus.force_relock_i = 0;
        model_reset();

        // {pll_rst, sys_rst, locked, fault, retry[3:0]}
        vecs[0] = '{1, 0, 0, 3,  8'hC0};
        vecs[1] = '{0, 0, 0, 3,  8'hC0};
        vecs[2] = '{0, 0, 0, 1,  8'h40};
        vecs[3] = '{0, 1, 0, 10, 8'h40};
        vecs[4] = '{0, 1, 0, 1,  8'h20};
        vecs[5] = '{0, 1, 0, 5,  8'h20};
        vecs[6] = '{1, 1, 0, 1,  8'hC0};
        vecs[7] = '{0, 0, 0, 2,  8'hC0};

        foreach (vecs[i]) begin
            for (int unsigned k = 0; k < vecs[i].n; k++) step(vecs[i].r, vecs[i].lk, vecs[i].fr);
            check($sformatf("vec%0d", i), {24'd0, dut_out()}, {24'd0, vecs[i].exp});
        end

        // Lock stuck low: three timeout windows, then FAULT.
        reset_dut();
        repeat (35) step(0, 0, 0);
        check("t2_before_first_timeout", {24'd0, dut_out()}, 32'h40);
        step(0, 0, 0);
        check("t2_retry1", {24'd0, dut_out()}, 32'hC1);
        repeat (71) step(0, 0, 0);
        check("t2_before_fault", {24'd0, dut_out()}, 32'h42);
        step(0, 0, 0);
        check("t2_fault", {24'd0, dut_out()}, 32'hD3);
        repeat (1000) step(0, 1'($urandom_range(0, 1)), 0);
        check("t2_fault_sticky", {24'd0, dut_out()}, 32'hD3);

        // Force relock out of FAULT.
        step(0, 1, 1);
        check("t3_force", {24'd0, dut_out()}, 32'hC0);
        count_pll_pulse(1, hi);
        check("t3_pll_rst_len", hi, RST_HOLD);
        wait_locked(seen);
        check("t3_relock", {31'd0, seen}, 1);

        // Glitch during filtering.
        reset_dut();
        repeat (4) step(0, 0, 0);
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        repeat (10) step(0, 1, 0);
        check("t4_no_early_lock", {24'd0, dut_out()}, 32'h40);
        step(0, 1, 0);
        check("t4_locked", {24'd0, dut_out()}, 32'h20);

        // Lock loss while locked.
        repeat (2) step(0, 0, 0);
        check("t5_still_locked", {24'd0, dut_out()}, 32'h20);
        step(0, 0, 0);
        check("t5_sys_rst", {24'd0, dut_out()}, 32'hC0);
        count_pll_pulse(1, hi);
        check("t5_pll_rst_len", hi, RST_HOLD);
        wait_locked(seen);
        check("t5_relock", {31'd0, seen}, 1);

        // rst mid-FILTER and mid-FAULT.
        reset_dut();
        repeat (4) step(0, 0, 0);
        repeat (4) step(0, 1, 0);
        check("t6_in_filter", {24'd0, dut_out()}, 32'h40);
        step(1, 1, 0);
        check("t6_rst_filter", {24'd0, dut_out()}, 32'hC0);
        repeat (108) step(0, 0, 0);
        check("t6_fault", {24'd0, dut_out()}, 32'hD3);
        step(1, 0, 0);
        check("t6_rst_fault", {24'd0, dut_out()}, 32'hC0);

        // Randomized traffic: persistent lock level with occasional flips, forces, resets.
        lk = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) lk = ~lk;
            fr = ($urandom_range(0, 299) == 0);
            r  = ($urandom_range(0, 699) == 0);
            step(r, lk, fr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
